lc3_control: RTL

LC3_CONTROL -- requirements
Module: lc3_control

---
 rtl/lc3_control.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/lc3_control.sv
// LC-3 style multicycle control unit: fetch/decode/execute FSM that drives
// the datapath selects, enables and load strobes. Outputs are registered from
// the next-state decode so each state's controls appear for exactly the
// cycles that state is occupied.
module lc3_control #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  output logic        selEAB1,
  output logic        enaALU,
  output logic        regWE,
  output logic        flagWE,
  output logic        enaMARM,
  output logic        selMAR,
  output logic        enaPC,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        selMDR,
  output logic        enaMDR,
  output logic [1:0]  aluControl,
  output logic [1:0]  selPC,
  output logic [1:0]  selEAB2,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [2:0]  DR,
  output logic        memWE,
  output logic        illegal,
  output logic        halted
);

  typedef enum logic [4:0] {
    S_START, S_F0, S_F1, S_F2, S_DEC, S_ALU, S_BR, S_JMP, S_LEA,
    S_LD0, S_LD1, S_LD2, S_ST0, S_ST1, S_ST2, S_ILL, S_HALT
  } state_t;

  typedef struct packed {
    logic       sel_eab1, ena_alu, reg_we, flag_we, ena_marm, sel_mar, ena_pc, ld_pc;
    logic       ld_ir, ld_mar, ld_mdr, sel_mdr, ena_mdr, mem_we, illegal, halted;
    logic [1:0] alu_control, sel_pc, sel_eab2;
    logic [2:0] sr1, sr2, dr;
  } ctrl_t;

  // Last value of the wait counter in a memory-access state.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t      state_r, state_next;
  logic [3:0]  cnt_r, cnt_next;
  ctrl_t       ctrl_r, ctrl_s;
  logic        br_take_s;
  logic        unused_s;

  assign br_take_s = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
  assign unused_s  = ^IR[5:3];

  // State, wait counter and registered controls; reset forces START with all controls low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_START;
      cnt_r   <= 4'd0;
      ctrl_r  <= '0;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
      ctrl_r  <= ctrl_s;
    end
  end

  // Next-state logic; the counter defaults to 0 so every wait state starts fresh.
  always_comb begin
    state_next = state_r;
    cnt_next   = 4'd0;
    case (state_r)
      S_START: state_next = S_F0;
      S_F0:    state_next = S_F1;
      S_F1: begin
        if (cnt_r == WAIT_LAST) begin
          state_next = S_F2;
        end else begin
          state_next = S_F1;
          cnt_next   = cnt_r + 4'd1;
        end
      end
      S_F2:    state_next = S_DEC;
      S_DEC: begin
        case (IR[15:12])
          4'b0001, 4'b0101, 4'b1001: state_next = S_ALU;
          4'b0000: state_next = S_BR;
          4'b1100: state_next = S_JMP;
          4'b1110: state_next = S_LEA;
          4'b0010: state_next = S_LD0;
          4'b0011: state_next = S_ST0;
          4'b1111: state_next = S_HALT;
          default: state_next = S_ILL;
        endcase
      end
      S_ALU, S_BR, S_JMP, S_LEA, S_LD2, S_ILL: state_next = S_F0;
      S_LD0:   state_next = S_LD1;
      S_LD1: begin
        if (cnt_r == WAIT_LAST) begin
          state_next = S_LD2;
        end else begin
          state_next = S_LD1;
          cnt_next   = cnt_r + 4'd1;
        end
      end
      S_ST0:   state_next = S_ST1;
      S_ST1:   state_next = S_ST2;
      S_ST2: begin
        if (cnt_r == WAIT_LAST) begin
          state_next = S_F0;
        end else begin
          state_next = S_ST2;
          cnt_next   = cnt_r + 4'd1;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_START;
    endcase
  end

  // Control decode for the state being entered, so registered outputs line up with it.
  always_comb begin
    ctrl_s = '0;
    case (state_next)
      S_F0: begin
        ctrl_s.ena_pc = 1'b1;
        ctrl_s.ld_mar = 1'b1;
        ctrl_s.ld_pc  = 1'b1;
      end
      S_F1, S_LD1: begin
        if (cnt_next == WAIT_LAST) begin
          ctrl_s.ld_mdr  = 1'b1;
          ctrl_s.sel_mdr = 1'b1;
        end else begin
          ctrl_s.ld_mdr  = 1'b0;
        end
      end
      S_F2: begin
        ctrl_s.ena_mdr = 1'b1;
        ctrl_s.ld_ir   = 1'b1;
      end
      S_ALU: begin
        ctrl_s.sr1         = IR[8:6];
        ctrl_s.sr2         = IR[2:0];
        ctrl_s.dr          = IR[11:9];
        ctrl_s.alu_control = IR[15:14];
        ctrl_s.ena_alu     = 1'b1;
        ctrl_s.reg_we      = 1'b1;
        ctrl_s.flag_we     = 1'b1;
      end
      S_BR: begin
        if (br_take_s) begin
          ctrl_s.ld_pc    = 1'b1;
          ctrl_s.sel_pc   = 2'd1;
          ctrl_s.sel_eab2 = 2'd2;
        end else begin
          ctrl_s.ld_pc    = 1'b0;
        end
      end
      S_JMP: begin
        ctrl_s.sr1      = IR[8:6];
        ctrl_s.sel_eab1 = 1'b1;
        ctrl_s.ld_pc    = 1'b1;
        ctrl_s.sel_pc   = 2'd1;
      end
      S_LEA: begin
        ctrl_s.sel_eab2 = 2'd2;
        ctrl_s.dr       = IR[11:9];
        ctrl_s.ena_marm = 1'b1;
        ctrl_s.reg_we   = 1'b1;
        ctrl_s.flag_we  = 1'b1;
      end
      S_LD0, S_ST0: begin
        ctrl_s.sel_eab2 = 2'd2;
        ctrl_s.ena_marm = 1'b1;
        ctrl_s.ld_mar   = 1'b1;
      end
      S_LD2: begin
        ctrl_s.dr      = IR[11:9];
        ctrl_s.ena_mdr = 1'b1;
        ctrl_s.reg_we  = 1'b1;
        ctrl_s.flag_we = 1'b1;
      end
      S_ST1: begin
        ctrl_s.sr1      = IR[11:9];
        ctrl_s.sel_eab1 = 1'b1;
        ctrl_s.ena_marm = 1'b1;
        ctrl_s.ld_mdr   = 1'b1;
      end
      S_ST2:   ctrl_s.mem_we  = 1'b1;
      S_ILL:   ctrl_s.illegal = 1'b1;
      S_HALT:  ctrl_s.halted  = 1'b1;
      default: ctrl_s = '0;
    endcase
  end

  assign selEAB1    = ctrl_r.sel_eab1;
  assign enaALU     = ctrl_r.ena_alu;
  assign regWE      = ctrl_r.reg_we;
  assign flagWE     = ctrl_r.flag_we;
  assign enaMARM    = ctrl_r.ena_marm;
  assign selMAR     = ctrl_r.sel_mar;
  assign enaPC      = ctrl_r.ena_pc;
  assign ldPC       = ctrl_r.ld_pc;
  assign ldIR       = ctrl_r.ld_ir;
  assign ldMAR      = ctrl_r.ld_mar;
  assign ldMDR      = ctrl_r.ld_mdr;
  assign selMDR     = ctrl_r.sel_mdr;
  assign enaMDR     = ctrl_r.ena_mdr;
  assign aluControl = ctrl_r.alu_control;
  assign selPC      = ctrl_r.sel_pc;
  assign selEAB2    = ctrl_r.sel_eab2;
  assign SR1        = ctrl_r.sr1;
  assign SR2        = ctrl_r.sr2;
  assign DR         = ctrl_r.dr;
  assign memWE      = ctrl_r.mem_we;
  assign illegal    = ctrl_r.illegal;
  assign halted     = ctrl_r.halted;

endmodule
